// File: rtl/fetch_unit_pkg.sv
// Shared processor package: opcode constants, the NOP word and the fetch
// state encoding. The decode stage imports the same definitions.
package fetch_unit_pkg;

  localparam logic [4:0] OP_LDM = 5'b00001;
  localparam logic [4:0] OP_STD = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_NOT = 5'b00100;
  localparam logic [4:0] OP_NOP = 5'b00101;

  localparam logic [31:0] NOP_WORD = {OP_NOP, 27'b0};

  typedef enum logic {
    S_FETCH = 1'b0,  // fetching the first word of an instruction
    S_IMM   = 1'b1   // fetching the immediate word of an LDM
  } fetch_state_t;

  // LDM is the only two-word instruction; undefined opcodes are one-word.
  function automatic logic is_two_word(input logic [4:0] op);
    return op == OP_LDM;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: decode-side control (stall/flush), instruction memory port
// and the instruction/pc outputs towards decode.
//   master : the fetch unit
//   slave  : the surrounding pipeline / memory
interface fetch_unit_if;
  logic        stall;
  logic        flush;
  logic [15:0] flush_pc;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic [15:0] pc;

  modport master (
    input  stall, flush, flush_pc, imem_data,
    output imem_addr, imem_rd, instr, instr_valid, pc
  );

  modport slave (
    output stall, flush, flush_pc, imem_data,
    input  imem_addr, imem_rd, instr, instr_valid, pc
  );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch unit.
//   clk, reset : clock, synchronous active-low reset (pc -> 0x0000)
//   load       : redirect, pc <= load_pc (wins over inc)
//   load_pc    : redirect target
//   inc        : advance pc by one word, 16-bit wrap
//   pc         : current fetch address
module fetch_pc_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_pc,
  input  logic        inc,
  output logic [15:0] pc
);

  always_ff @(posedge clk) begin
    if (!reset)    pc <= 16'h0000;
    else if (load) pc <= load_pc;
    else if (inc)  pc <= pc + 16'h0001;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit. Reads one 16-bit word per cycle from an
// asynchronous instruction memory and assembles 32-bit instructions for
// decode: one-word opcodes are padded with a zero low half, LDM takes its
// immediate from the following word.
//   clk, reset : clock, synchronous active-low reset
//   bus        : fetch_unit_if.master (stall/flush/flush_pc in, imem port,
//                instr/instr_valid/pc out)
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  fetch_state_t state_q, state_d;
  logic [15:0]  hi_q, hi_d;
  logic [31:0]  instr_q, instr_d;
  logic         vld_q, vld_d;
  logic [15:0]  pc;

  // Every non-stalled fetch consumes exactly one word, in either state.
  fetch_pc_reg u_pc (
    .clk     (clk),
    .reset   (reset),
    .load    (bus.flush),
    .load_pc (bus.flush_pc),
    .inc     (!bus.stall),
    .pc      (pc)
  );

  assign bus.imem_addr   = pc;
  assign bus.imem_rd     = reset & ~bus.flush & ~bus.stall;
  assign bus.pc          = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = vld_q;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    if (bus.flush) begin
      // Drops any half-fetched LDM.
      state_d = S_FETCH;
      instr_d = NOP_WORD;
      vld_d   = 1'b0;
    end else if (!bus.stall) begin
      case (state_q)
        S_FETCH: begin
          if (is_two_word(bus.imem_data[15:11])) begin
            hi_d    = bus.imem_data;
            instr_d = NOP_WORD;
            vld_d   = 1'b0;
            state_d = S_IMM;
          end else begin
            instr_d = {bus.imem_data, 16'h0000};
            vld_d   = 1'b1;
          end
        end
        S_IMM: begin
          instr_d = {hi_q, bus.imem_data};
          vld_d   = 1'b1;
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      hi_q    <= 16'h0000;
      instr_q <= NOP_WORD;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: directed scenarios followed by random
// memory contents with random stall/flush/reset traffic.
module tb_fetch_unit;

  localparam logic [31:0] NOP_W = 32'h2800_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit dut (.clk(clk), .reset(reset), .bus(bus));

  logic [15:0] mem [65536];
  assign bus.imem_data = mem[bus.imem_addr];

  typedef struct {
    logic [31:0] instr;
    logic        vld;
    logic [15:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: the stream of words is grouped into instructions;
  // "pending" marks that the next word completes an LDM.
  logic [15:0] m_pc;
  logic [15:0] m_hi;
  bit          m_pending;
  logic [31:0] m_instr;
  logic        m_vld;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Drive one cycle and push the model's post-edge expectation.
  task automatic step(input bit r, input bit st, input bit fl, input logic [15:0] fp);
    logic [15:0] w;
    exp_t e;
    @(negedge clk);
    reset = r; bus.stall = st; bus.flush = fl; bus.flush_pc = fp;
    #1;
    check("imem_rd", {31'b0, bus.imem_rd}, {31'b0, r && !fl && !st});
    if (r) check("imem_addr", {16'b0, bus.imem_addr}, {16'b0, m_pc});
    if (!r) begin
      m_pc = 16'h0; m_hi = 16'h0; m_pending = 0; m_instr = NOP_W; m_vld = 0;
    end else if (fl) begin
      m_pc = fp; m_pending = 0; m_instr = NOP_W; m_vld = 0;
    end else if (!st) begin
      w = mem[m_pc];
      if (m_pending) begin
        m_instr = {m_hi, w}; m_vld = 1; m_pending = 0;
      end else if (w[15:11] == 5'd1) begin
        m_hi = w; m_pending = 1; m_instr = NOP_W; m_vld = 0;
      end else begin
        m_instr = {w, 16'h0}; m_vld = 1;
      end
      m_pc = 16'((32'(m_pc) + 1) % 65536);
    end
    e.instr = m_instr; e.vld = m_vld; e.pc = m_pc;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: compares the registered outputs after every edge that has a
  // pending expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("instr", bus.instr, e.instr);
      check("instr_valid", {31'b0, bus.instr_valid}, {31'b0, e.vld});
      check("pc", {16'b0, bus.pc}, {16'b0, e.pc});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h2800;
    reset = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0; bus.flush_pc = 16'h0;
    m_pc = 0; m_hi = 0; m_pending = 0; m_instr = NOP_W; m_vld = 0;

    // Reset values.
    step(0, 0, 0, 0);
    check("rst_instr", bus.instr, 32'h2800_0000);
    check("rst_vld", {31'b0, bus.instr_valid}, 32'd0);
    check("rst_pc", {16'b0, bus.pc}, 32'd0);

    // ADD, NOT, NOP back to back.
    mem[0] = 16'h1A00; mem[1] = 16'h2000; mem[2] = 16'h2800;
    step(1, 0, 0, 0);
    check("seq_add", bus.instr, 32'h1A00_0000);
    check("seq_pc1", {16'b0, bus.pc}, 32'd1);
    // Stall for three cycles after the ADD.
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      check("stall_instr", bus.instr, 32'h1A00_0000);
      check("stall_pc", {16'b0, bus.pc}, 32'd1);
    end
    step(1, 0, 0, 0);
    check("seq_not", bus.instr, 32'h2000_0000);
    step(1, 0, 0, 0);
    check("seq_nop", bus.instr, 32'h2800_0000);
    check("seq_pc3", {16'b0, bus.pc}, 32'd3);

    // LDM with immediate.
    step(0, 0, 0, 0);
    mem[0] = 16'h0900; mem[1] = 16'hBEEF;
    step(1, 0, 0, 0);
    check("ldm_c1_vld", {31'b0, bus.instr_valid}, 32'd0);
    check("ldm_c1_instr", bus.instr, 32'h2800_0000);
    step(1, 0, 0, 0);
    check("ldm_c2_instr", bus.instr, 32'h0900_BEEF);
    check("ldm_c2_pc", {16'b0, bus.pc}, 32'd2);

    // Flush while waiting for the LDM immediate.
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 16'h0040);
    check("flush_pc", {16'b0, bus.pc}, 32'h40);
    check("flush_instr", bus.instr, 32'h2800_0000);
    check("flush_vld", {31'b0, bus.instr_valid}, 32'd0);
    step(1, 0, 0, 0);
    check("flush_no_ldm", bus.instr, 32'h2800_0000);

    // LDM straddling the top of memory.
    mem[16'hFFFF] = 16'h0900; mem[0] = 16'h1234;
    step(1, 0, 1, 16'hFFFF);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("wrap_instr", bus.instr, 32'h0900_1234);
    check("wrap_pc", {16'b0, bus.pc}, 32'd1);

    // Reset wins over flush and stall, including mid-LDM.
    step(1, 0, 0, 0);
    step(0, 1, 1, 16'h0077);
    check("rst_pri_instr", bus.instr, 32'h2800_0000);
    check("rst_pri_vld", {31'b0, bus.instr_valid}, 32'd0);
    check("rst_pri_pc", {16'b0, bus.pc}, 32'd0);

    // Random memory and random control traffic.
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 2) == 0) w[15:11] = 5'd1;
      else w[15:11] = 5'($urandom_range(0, 7));
      mem[i] = w;
    end
    for (int i = 0; i < 3000; i++) begin
      bit r, st, fl;
      logic [15:0] fp;
      r  = ($urandom_range(0, 60) != 0);
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 15) == 0);
      fp = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3))
                                       : 16'($urandom);
      step(r, st, fl, fp);
    end

    @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
